// File: rtl/hub75_pkg.sv
// Shared constants and types for the HUB75 receiver: default geometry,
// error-flag bit positions and the one-hot stream FSM encoding.
package hub75_pkg;

  localparam int WIDTH_DEF       = 64;
  localparam int ADDR_BITS_DEF   = 5;
  localparam int SYNC_STAGES_DEF = 2;

  localparam int ERR_LONG      = 0;
  localparam int ERR_SHORT     = 1;
  localparam int ERR_UNBLANKED = 2;
  localparam int ERR_OVERRUN   = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b01,
    ST_STREAM = 2'b10
  } state_e;

endpackage

// File: rtl/hub75_if.sv
// HUB75 panel pins plus the rebuilt pixel stream. The master side is the LED
// driver / pixel consumer, the slave side is the receiver.
interface hub75_if
  import hub75_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF
) ();

  logic [2:0]             led_rgb0;
  logic [2:0]             led_rgb1;
  logic [ADDR_BITS-1:0]   led_addr;
  logic                   led_blank;
  logic                   led_latch;
  logic                   led_sclk;

  logic                   out_valid;
  logic                   out_ready;
  logic [$clog2(WIDTH)-1:0] out_x;
  logic [ADDR_BITS:0]     out_y0;
  logic [2:0]             out_rgb0;
  logic [2:0]             out_rgb1;
  logic                   out_last;

  modport master (
    output led_rgb0, led_rgb1, led_addr, led_blank, led_latch, led_sclk, out_ready,
    input  out_valid, out_x, out_y0, out_rgb0, out_rgb1, out_last
  );

  modport slave (
    input  led_rgb0, led_rgb1, led_addr, led_blank, led_latch, led_sclk, out_ready,
    output out_valid, out_x, out_y0, out_rgb0, out_rgb1, out_last
  );

endinterface

// File: rtl/hub75_sync.sv
// N-stage synchroniser for a bus of asynchronous pins, with a rising-edge
// detector comparing the last synchronised stage against its previous value.
module hub75_sync
  import hub75_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF,
  parameter int W      = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise
);

  logic [W-1:0] sync_r [STAGES];
  logic [W-1:0] prev_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_r[i] <= {W{1'b0}};
      end
      prev_r <= {W{1'b0}};
    end else begin
      sync_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_r <= sync_r[STAGES-1];
    end
  end

  assign q    = sync_r[STAGES-1];
  assign rise = sync_r[STAGES-1] & ~prev_r;

endmodule

// File: rtl/hub75_receiver.sv
// Panel-side HUB75 sink: rebuilds each shifted row in a staging buffer, commits
// it on the latch edge and streams the committed row out as valid/ready pixels.
module hub75_receiver
  import hub75_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int ADDR_BITS   = ADDR_BITS_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic       pll_clk,
  input  logic       reset,
  hub75_if.slave     bus,
  output logic       frame_done,
  output logic [3:0] err_flags,
  input  logic       err_clear
);

  localparam int XW = $clog2(WIDTH);
  localparam int BW = 6 + ADDR_BITS + 3;
  localparam logic [XW:0]          COL_FULL = (XW+1)'(WIDTH);
  localparam logic [XW-1:0]        X_LAST   = {XW{1'b1}};
  localparam logic [ADDR_BITS-1:0] ROW_LAST = {ADDR_BITS{1'b1}};

  logic [BW-1:0]        pins_s, level_s, rise_s;
  logic                 unused_s;
  logic [2:0]           rgb0_s, rgb1_s;
  logic [ADDR_BITS-1:0] addr_s;
  logic                 blank_s, sclk_rise_s, latch_rise_s;
  logic                 shift_s, commit_s, accept_s, last_s;
  logic [XW:0]          col_after_s;
  logic [3:0]           err_set_s;
  state_e               state_r, state_next_s;

  logic [XW:0]          col_r;
  logic [5:0]           stage_r  [WIDTH];
  logic [5:0]           commit_r [WIDTH];
  logic [XW-1:0]        x_r;
  logic [ADDR_BITS-1:0] row_r;
  logic                 frame_done_r;
  logic [3:0]           err_r;

  assign pins_s = {bus.led_rgb1, bus.led_rgb0, bus.led_addr,
                   bus.led_blank, bus.led_latch, bus.led_sclk};

  hub75_sync #(.STAGES(SYNC_STAGES), .W(BW)) u_sync (
    .clk   (pll_clk),
    .reset (reset),
    .d     (pins_s),
    .q     (level_s),
    .rise  (rise_s)
  );

  assign {rgb1_s, rgb0_s, addr_s, blank_s} = level_s[BW-1:2];
  assign sclk_rise_s  = rise_s[0];
  assign latch_rise_s = rise_s[1];
  assign unused_s     = ^{rise_s[BW-1:2], level_s[1:0]};

  assign shift_s     = sclk_rise_s && (col_r < COL_FULL);
  assign col_after_s = col_r + {{XW{1'b0}}, shift_s};
  assign commit_s    = latch_rise_s && (state_r == ST_IDLE);
  assign last_s      = (x_r == X_LAST);
  assign accept_s    = (state_r == ST_STREAM) && bus.out_ready;

  // Conditions that raise sticky error bits this cycle
  always_comb begin
    err_set_s = 4'b0000;
    if (latch_rise_s) begin
      err_set_s[ERR_UNBLANKED] = !blank_s;
      err_set_s[ERR_SHORT]     = (col_after_s != COL_FULL);
      err_set_s[ERR_OVERRUN]   = (state_r != ST_IDLE);
    end else begin
      err_set_s[ERR_UNBLANKED] = 1'b0;
    end
    err_set_s[ERR_LONG] = sclk_rise_s && (col_r == COL_FULL);
  end

  always_ff @(posedge pll_clk or posedge reset) begin
    if (reset) begin
      col_r <= {(XW+1){1'b0}};
      for (int i = 0; i < WIDTH; i++) stage_r[i] <= 6'd0;
    end else if (latch_rise_s) begin
      col_r <= {(XW+1){1'b0}};
      for (int i = 0; i < WIDTH; i++) stage_r[i] <= 6'd0;
    end else if (shift_s) begin
      stage_r[col_r[XW-1:0]] <= {rgb1_s, rgb0_s};
      col_r                  <= col_after_s;
    end
  end

  // A column shifted in the latch cycle still lands in the committed row
  always_ff @(posedge pll_clk) begin
    if (commit_s) begin
      for (int i = 0; i < WIDTH; i++) begin
        commit_r[i] <= (shift_s && (col_r[XW-1:0] == XW'(i))) ? {rgb1_s, rgb0_s} : stage_r[i];
      end
    end
  end

  always_ff @(posedge pll_clk or posedge reset) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_next_s;
  end

  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (commit_s) state_next_s = ST_STREAM;
        else          state_next_s = ST_IDLE;
      end
      ST_STREAM: begin
        if (accept_s && last_s) state_next_s = ST_IDLE;
        else                    state_next_s = ST_STREAM;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  always_ff @(posedge pll_clk or posedge reset) begin
    if (reset) begin
      x_r          <= {XW{1'b0}};
      row_r        <= {ADDR_BITS{1'b0}};
      frame_done_r <= 1'b0;
      err_r        <= 4'b0000;
    end else begin
      frame_done_r <= commit_s && (addr_s == ROW_LAST);
      err_r        <= err_clear ? 4'b0000 : (err_r | err_set_s);
      if (commit_s) begin
        x_r   <= {XW{1'b0}};
        row_r <= addr_s;
      end else if (accept_s) begin
        x_r <= x_r + XW'(1);
      end
    end
  end

  always_comb begin
    bus.out_valid = (state_r == ST_STREAM);
    bus.out_x     = x_r;
    bus.out_y0    = {1'b0, row_r};
    if (state_r == ST_STREAM) begin
      {bus.out_rgb1, bus.out_rgb0} = commit_r[x_r];
      bus.out_last                 = last_s;
    end else begin
      {bus.out_rgb1, bus.out_rgb0} = 6'd0;
      bus.out_last                 = 1'b0;
    end
  end

  assign frame_done = frame_done_r;
  assign err_flags  = err_r;

endmodule

// File: tb/tb_hub75_receiver.sv
// Bench for hub75_receiver: drives driver-style HUB75 pin timing and checks
// every accepted beat against a queue of rows predicted from the pin activity.
module tb_hub75_receiver;
  import hub75_pkg::*;

  localparam int W  = 64;
  localparam int AB = 5;

  typedef struct {
    int         x;
    int         y;
    logic [2:0] r0;
    logic [2:0] r1;
  } beat_t;

  logic       pll_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       frame_done;
  logic [3:0] err_flags;
  logic       err_clear = 1'b0;

  hub75_if #(.WIDTH(W), .ADDR_BITS(AB)) bus ();

  hub75_receiver #(.WIDTH(W), .ADDR_BITS(AB), .SYNC_STAGES(2)) dut (
    .pll_clk    (pll_clk),
    .reset      (reset),
    .bus        (bus),
    .frame_done (frame_done),
    .err_flags  (err_flags),
    .err_clear  (err_clear)
  );

  always #5 pll_clk = ~pll_clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  beat_t       exp_q[$];
  logic [5:0]  m_stage [W];
  int          m_col = 0;
  logic [3:0]  m_err = 4'b0000;
  logic [5:0]  captured [W];
  int          beats = 0;
  int          fd_seen = 0;
  bit          rnd_ready = 1'b0;
  bit          held = 1'b0;
  logic [18:0] held_beat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Checker: every accepted beat must be the next one the model predicts
  always @(negedge pll_clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      if (frame_done) begin
        fd_seen++;
        check("frame_done_row", bus.out_y0, 6'd31);
      end
      if (held) begin
        check("valid_held", bus.out_valid, 1'b1);
        check("stall_stable", {bus.out_x, bus.out_y0, bus.out_rgb0, bus.out_rgb1, bus.out_last}, held_beat);
      end
      held = 1'b0;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", bus.out_valid, 1'b0);
        end else if (bus.out_ready) begin
          beat_t b;
          b = exp_q.pop_front();
          check("beat_x",    bus.out_x,    b.x);
          check("beat_y0",   bus.out_y0,   b.y);
          check("beat_rgb0", bus.out_rgb0, b.r0);
          check("beat_rgb1", bus.out_rgb1, b.r1);
          check("beat_last", bus.out_last, (b.x == W-1));
          captured[bus.out_x] = {bus.out_rgb1, bus.out_rgb0};
          beats++;
        end else begin
          held      = 1'b1;
          held_beat = {bus.out_x, bus.out_y0, bus.out_rgb0, bus.out_rgb1, bus.out_last};
        end
      end
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pll_clk);
      #1;
      if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic shift_col(input logic [2:0] r0, input logic [2:0] r1);
    bus.led_rgb0 = r0;
    bus.led_rgb1 = r1;
    cyc(2);
    bus.led_sclk = 1'b1;
    if (m_col < W) begin
      m_stage[m_col] = {r1, r0};
      m_col++;
    end else begin
      m_err[ERR_LONG] = 1'b1;
    end
    cyc(2);
    bus.led_sclk = 1'b0;
  endtask

  task automatic latch_row(input logic [4:0] addr, input logic blanked);
    bus.led_addr  = addr;
    bus.led_blank = blanked;
    cyc(2);
    bus.led_latch = 1'b1;
    if (!blanked)   m_err[ERR_UNBLANKED] = 1'b1;
    if (m_col != W) m_err[ERR_SHORT] = 1'b1;
    if (exp_q.size() == 0) begin
      for (int x = 0; x < W; x++) begin
        beat_t b;
        b.x = x; b.y = int'(addr); b.r0 = m_stage[x][2:0]; b.r1 = m_stage[x][5:3];
        exp_q.push_back(b);
      end
    end else begin
      m_err[ERR_OVERRUN] = 1'b1;
    end
    for (int x = 0; x < W; x++) m_stage[x] = 6'd0;
    m_col = 0;
    cyc(2);
    bus.led_latch = 1'b0;
    cyc(1);
    bus.led_blank = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      cyc(1);
      k++;
    end
    check("drain_in_budget", exp_q.size(), 0);
    cyc(4);
  endtask

  task automatic clear_err();
    err_clear = 1'b1;
    cyc(1);
    err_clear = 1'b0;
    m_err = 4'b0000;
    cyc(1);
    check("err_cleared", err_flags, 4'b0000);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.led_rgb0 = 3'd0; bus.led_rgb1 = 3'd0; bus.led_addr = 5'd0;
    bus.led_blank = 1'b1; bus.led_latch = 1'b0; bus.led_sclk = 1'b0;
    bus.out_ready = 1'b1;
    for (int x = 0; x < W; x++) begin m_stage[x] = 6'd0; captured[x] = 6'd0; end

    cyc(3);
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_err", err_flags, 4'b0000);
    check("rst_beat", {bus.out_x, bus.out_y0, bus.out_rgb0, bus.out_rgb1, bus.out_last}, 19'd0);
    reset = 1'b0;
    cyc(3);

    // Full row, x-dependent data, addr 5
    beats = 0;
    for (int x = 0; x < W; x++) shift_col(3'(x % 8), 3'(x / 8));
    latch_row(5'd5, 1'b1);
    wait_idle(500);
    check("row5_beats", beats, 64);
    check("row5_px0",   captured[0],  6'b000_000);
    check("row5_px10",  captured[10], 6'b001_010);
    check("row5_px63",  captured[63], 6'b111_111);
    check("row5_err",   err_flags, 4'b0000);

    // Short row: 40 columns
    for (int x = 0; x < 40; x++) shift_col(3'd5, 3'd2);
    latch_row(5'd6, 1'b1);
    wait_idle(500);
    check("short_px39", captured[39], 6'b010_101);
    check("short_px40", captured[40], 6'b000_000);
    check("short_err_model", err_flags, m_err);
    check("short_err", err_flags, 4'b0010);
    clear_err();

    // Long row: 70 columns
    for (int x = 0; x < 70; x++) shift_col(3'(x % 8), 3'd1);
    latch_row(5'd7, 1'b1);
    wait_idle(500);
    check("long_px63", captured[63], 6'b001_111);
    check("long_err_model", err_flags, m_err);
    check("long_err", err_flags, 4'b0001);
    clear_err();

    // Overrun: stall first row, latch a second one
    bus.out_ready = 1'b0;
    beats = 0;
    for (int x = 0; x < W; x++) shift_col(3'd3, 3'd4);
    latch_row(5'd8, 1'b1);
    cyc(10);
    check("stall_valid", bus.out_valid, 1'b1);
    check("stall_x", bus.out_x, 0);
    check("stall_y0", bus.out_y0, 6'd8);
    for (int x = 0; x < W; x++) shift_col(3'd6, 3'd6);
    latch_row(5'd9, 1'b1);
    cyc(6);
    check("ovr_err_model", err_flags, m_err);
    check("ovr_err", err_flags, 4'b1000);
    bus.out_ready = 1'b1;
    wait_idle(500);
    cyc(20);
    check("ovr_beats", beats, 64);
    check("ovr_px0", captured[0], 6'b100_011);
    check("ovr_no_second", bus.out_valid, 1'b0);
    clear_err();

    // Latch while unblanked
    for (int x = 0; x < W; x++) shift_col(3'd1, 3'd2);
    latch_row(5'd10, 1'b0);
    wait_idle(500);
    check("unbl_err_model", err_flags, m_err);
    check("unbl_err", err_flags, 4'b0100);
    clear_err();

    // Full 32-row frame under random back-pressure
    fd_seen = 0;
    beats = 0;
    rnd_ready = 1'b1;
    for (int a = 0; a < 32; a++) begin
      for (int x = 0; x < W; x++) shift_col(3'((a + x) % 8), 3'((x / 8 + a) % 8));
      wait_idle(2000);
      latch_row(5'(a), 1'b1);
    end
    wait_idle(2000);
    rnd_ready = 1'b0;
    bus.out_ready = 1'b1;
    check("frame_beats", beats, 2048);
    check("frame_done_count", fd_seen, 1);
    check("frame_err", err_flags, 4'b0000);

    // Reset in the middle of a streamed row
    for (int x = 0; x < W; x++) shift_col(3'd7, 3'd7);
    latch_row(5'd3, 1'b1);
    begin
      int k;
      k = 0;
      while (!bus.out_valid && k < 20) begin cyc(1); k++; end
    end
    check("mid_stream_started", bus.out_valid, 1'b1);
    cyc(10);
    reset = 1'b1;
    exp_q.delete();
    for (int x = 0; x < W; x++) m_stage[x] = 6'd0;
    m_col = 0;
    m_err = 4'b0000;
    @(negedge pll_clk);
    check("abort_valid", bus.out_valid, 1'b0);
    check("abort_frame_done", frame_done, 1'b0);
    check("abort_err", err_flags, 4'b0000);
    check("abort_rgb", {bus.out_rgb0, bus.out_rgb1, bus.out_last}, 7'd0);
    cyc(2);
    reset = 1'b0;
    cyc(10);
    check("post_reset_idle", bus.out_valid, 1'b0);
    check("frame_done_total", fd_seen, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
